fp_wb_queue: RTL and testbench

Result buffer directly downstream of the FP execution unit.
- Captures each completed FP result (data, destination, exception flags) the cycle the unit signals it.
- Presents results in completion order to the register-file writeback port over a valid/ready handshake.
- Accumulates the popped exception flags into a sticky fflags value for fcsr.
- The FP unit has no backpressure, so this block gives a credit-style issue_ok to the issue stage and flags overflow if that credit is ignored.

---
 rtl/fp_wb_queue.sv | 114 +++++++++++
 tb/tb_fp_wb_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_queue.sv
// Writeback buffer behind the FP execution unit: captures completed results in order,
// hands them to the register-file writeback port, accumulates sticky fflags and gives issue credit.
module fp_wb_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RESERVE = 2
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_result,
  input  logic [4:0]               in_flags,
  input  logic [4:0]               in_waddr,
  input  logic                     in_int_dest,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [XLEN-1:0]          wb_result,
  output logic [4:0]               wb_waddr,
  output logic                     wb_int_dest,
  output logic [4:0]               wb_flags,
  output logic [4:0]               fflags_acc,
  input  logic                     fflags_clr,
  output logic                     issue_ok,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] res_mem   [DEPTH];
  logic [4:0]      flags_mem [DEPTH];
  logic [4:0]      waddr_mem [DEPTH];
  logic            intd_mem  [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fflags_q, fflags_d;
  logic          overflow_q, overflow_d;
  logic          issue_ok_q, issue_ok_d;

  logic full, push, pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    wb_valid = (count_q != '0);
    pop      = wb_valid && wb_ready && !clear;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    push     = in_valid && !clear && (!full || pop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    fflags_d = fflags_q;
    if (pop)             fflags_d = (fflags_clr ? 5'b0 : fflags_q) | wb_flags;
    else if (fflags_clr) fflags_d = '0;

    overflow_d = overflow_q | (in_valid && !clear && full && !pop);
    issue_ok_d = (32'(count_d) + RESERVE) < DEPTH;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fflags_q   <= '0;
      overflow_q <= 1'b0;
      issue_ok_q <= 1'b1;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
      overflow_q <= overflow_d;
      issue_ok_q <= issue_ok_d;
    end
  end

  // Storage is intentionally not reset; occupancy is governed by count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      res_mem[wr_ptr_q]   <= in_result;
      flags_mem[wr_ptr_q] <= in_flags;
      waddr_mem[wr_ptr_q] <= in_waddr;
      intd_mem[wr_ptr_q]  <= in_int_dest;
    end
  end

  always_comb begin
    wb_result   = res_mem[rd_ptr_q];
    wb_flags    = flags_mem[rd_ptr_q];
    wb_waddr    = waddr_mem[rd_ptr_q];
    wb_int_dest = intd_mem[rd_ptr_q];
    fflags_acc  = fflags_q;
    overflow    = overflow_q;
    issue_ok    = issue_ok_q;
    count       = count_q;
  end

endmodule

// File: tb/tb_fp_wb_queue.sv
// Self-checking bench for fp_wb_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fp_wb_queue;

  localparam int unsigned D   = 4;
  localparam int unsigned XL  = 64;
  localparam int unsigned RES = 2;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          clear, in_valid, in_int_dest, wb_ready, fflags_clr;
  logic [XL-1:0] in_result;
  logic [4:0]    in_flags, in_waddr;
  logic          wb_valid, wb_int_dest, issue_ok, overflow;
  logic [XL-1:0] wb_result;
  logic [4:0]    wb_waddr, wb_flags, fflags_acc;
  logic [$clog2(D):0] count;

  int checks = 0;
  int fails  = 0;

  fp_wb_queue #(.DEPTH(D), .XLEN(XL), .RESERVE(RES)) dut (
    .clock(clock), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_result(in_result), .in_flags(in_flags),
    .in_waddr(in_waddr), .in_int_dest(in_int_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_waddr(wb_waddr), .wb_int_dest(wb_int_dest), .wb_flags(wb_flags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .issue_ok(issue_ok),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XL-1:0] res;
    logic [4:0]    fl;
    logic [4:0]    wa;
    logic          id;
  } entry_t;

  entry_t     mq[$];
  logic [4:0] macc;
  logic       movf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of entries, sticky flag accumulator and overflow bit.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      macc = '0;
      movf = 1'b0;
    end else begin
      bit p;
      entry_t e;
      p = (mq.size() > 0) && wb_ready && !clear;
      if (p)               macc = (fflags_clr ? 5'b0 : macc) | mq[0].fl;
      else if (fflags_clr) macc = '0;
      if (clear) mq.delete();
      else begin
        if (p) void'(mq.pop_front());
        if (in_valid) begin
          if (mq.size() < D) begin
            e.res = in_result; e.fl = in_flags; e.wa = in_waddr; e.id = in_int_dest;
            mq.push_back(e);
          end else movf = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (rst_n) begin
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("m_wb_result", wb_result, mq[0].res);
        chk("m_wb_flags", 64'(wb_flags), 64'(mq[0].fl));
        chk("m_wb_waddr", 64'(wb_waddr), 64'(mq[0].wa));
        chk("m_wb_int_dest", 64'(wb_int_dest), 64'(mq[0].id));
      end
      chk("m_fflags_acc", 64'(fflags_acc), 64'(macc));
      chk("m_overflow", 64'(overflow), 64'(movf));
      chk("m_issue_ok", 64'(issue_ok), 64'((mq.size() + RES) < D));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XL-1:0] r, input logic [4:0] f,
                       input logic [4:0] wa, input logic rdy);
    in_valid = v; in_result = r; in_flags = f; in_waddr = wa; wb_ready = rdy;
    in_int_dest = wa[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; fflags_clr = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    #12 rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_issue_ok", 64'(issue_ok), 64'd1);
    chk("rst_fflags", 64'(fflags_acc), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // single result
    @(posedge clock); #1;
    drive(1'b1, 64'h3FF0000000000000, 5'h01, 5'd5, 1'b1);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_result", wb_result, 64'h3FF0000000000000);
    chk("single_waddr", 64'(wb_waddr), 64'd5);
    cyc();
    chk("single_drain", 64'(wb_valid), 64'd0);
    chk("single_fflags", 64'(fflags_acc), 64'h01);
    chk("single_count", 64'(count), 64'd0);

    // fill with backpressure
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 5'h00, 5'(i), 1'b0);
      cyc();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_issue_ok", 64'(issue_ok), 64'(i < 2));
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    cyc(); cyc();
    chk("stall_head", wb_result, 64'd1);
    chk("stall_count", 64'(count), 64'd4);
    wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", wb_result, 64'(i));
      cyc();
    end
    chk("drain_empty", 64'(wb_valid), 64'd0);

    // full push+pop, then overflow
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 5'h00, 5'(i), 1'b0);
      cyc();
    end
    drive(1'b1, 64'd5, 5'h00, 5'd5, 1'b1);
    cyc();
    chk("fullpp_count", 64'(count), 64'd4);
    chk("fullpp_head", wb_result, 64'd2);
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    drive(1'b1, 64'd6, 5'h00, 5'd6, 1'b0);
    cyc();
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      chk("ovf_order", wb_result, 64'(i));
      cyc();
    end
    chk("ovf_empty", 64'(wb_valid), 64'd0);

    // flags
    fflags_clr = 1'b1; cyc(); fflags_clr = 1'b0;
    chk("fclr_nopop", 64'(fflags_acc), 64'd0);
    drive(1'b1, 64'hA, 5'h10, 5'd1, 1'b0); cyc();
    drive(1'b1, 64'hB, 5'h04, 5'd2, 1'b0); cyc();
    drive(1'b0, '0, '0, '0, 1'b1); cyc(); cyc();
    chk("flags_acc14", 64'(fflags_acc), 64'h14);
    drive(1'b1, 64'hC, 5'h02, 5'd3, 1'b0); cyc();
    drive(1'b0, '0, '0, '0, 1'b1); fflags_clr = 1'b1; cyc(); fflags_clr = 1'b0;
    chk("flags_clrpop", 64'(fflags_acc), 64'h02);
    drive(1'b1, 64'hD, 5'h08, 5'd4, 1'b0); cyc();
    drive(1'b0, '0, '0, '0, 1'b0); clear = 1'b1; cyc(); clear = 1'b0;
    chk("flags_clear", 64'(fflags_acc), 64'h02);

    // clear with simultaneous push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(i + 32), 5'h00, 5'(i), 1'b0); cyc();
    end
    chk("pre_clear_count", 64'(count), 64'd3);
    drive(1'b1, 64'h77, 5'h1F, 5'd9, 1'b1); clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_valid", 64'(wb_valid), 64'd0);
    drive(1'b0, '0, '0, '0, 1'b1); cyc();
    chk("clear_nocapture", 64'(count), 64'd0);

    // random traffic, pointers wrap many times
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom),
            5'($urandom), 1'($urandom_range(0, 1)));
      fflags_clr = ($urandom_range(0, 15) == 0);
      clear      = ($urandom_range(0, 31) == 0);
      cyc();
    end

    // build up state, then asynchronous reset mid-cycle
    clear = 1'b0; fflags_clr = 1'b0;
    drive(1'b1, 64'h55, 5'h1F, 5'd7, 1'b1); cyc();
    drive(1'b1, 64'h66, 5'h03, 5'd8, 1'b0); cyc(); cyc();
    @(posedge clock); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(wb_valid), 64'd0);
    chk("arst_fflags", 64'(fflags_acc), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_issue_ok", 64'(issue_ok), 64'd1);
    @(negedge clock); #1;
    rst_n = 1'b1;
    cyc();

    // credit-respecting random traffic: overflow must never appear
    for (int i = 0; i < 300; i++) begin
      drive(issue_ok && ($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom),
            5'($urandom), 1'($urandom_range(0, 1)));
      fflags_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    drive(1'b0, '0, '0, '0, 1'b1); fflags_clr = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("final_overflow", 64'(overflow), 64'd0);
    chk("final_empty", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
